// File: rtl/vec_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vec_lsu
//  Purpose  : Vector load/store unit, initiator side of the word-addressed
//             data-memory port. Accepts one (base, stride, len) command,
//             issues one word access per cycle, gathers load lanes into
//             load_data or scatters store lanes taken from store_data.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   clock
//    rst         in   synchronous reset, active low
//    start       in   command request, sampled only in IDLE
//    op          in   0 = load, 1 = store
//    base        in   word address of element 0
//    stride      in   two's-complement word-address increment per element
//    len         in   element count, values above VLEN clamp to VLEN
//    store_data  in   store lanes, lane i = bits [i*DW +: DW]
//    load_data   out  gathered load lanes
//    busy        out  command in progress (element cycles)
//    done        out  one-cycle completion pulse
//    err         out  sticky out-of-range flag for the last command
//    mem_addr    out  data-memory word address
//    mem_wdata   out  data-memory write data
//    mem_we      out  data-memory write enable
//    mem_re      out  data-memory read enable
//    mem_rdata   in   data-memory read data (combinational with addr/re)
// ============================================================================
module vec_lsu #(
  parameter int VLEN      = 8,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MEM_DEPTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [AW-1:0]      base,
  input  logic [AW-1:0]      stride,
  input  logic [3:0]         len,
  input  logic [VLEN*DW-1:0] store_data,
  output logic [VLEN*DW-1:0] load_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [DW-1:0]      mem_rdata
);

  localparam logic [3:0]    C_VLEN  = 4'(VLEN);
  localparam logic [AW-1:0] C_DEPTH = AW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched command
  logic          r_op;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_stride;
  logic [3:0]    r_len;
  logic [3:0]    r_idx;
  logic          r_err;
  logic [DW-1:0] r_store_lane [VLEN];
  logic [DW-1:0] r_load_lane  [VLEN];

  logic [3:0]    w_len_clamp;
  logic          w_in_range;
  logic          w_last;
  logic [DW-1:0] w_wlane;

  assign w_len_clamp = (len > C_VLEN) ? C_VLEN : len;
  assign w_in_range  = (r_addr < C_DEPTH);
  assign w_last      = (r_idx == (r_len - 4'd1));

  // Lane mux for the store word of the current element.
  always_comb begin
    w_wlane = '0;
    for (int j = 0; j < VLEN; j++) begin
      if (r_idx == 4'(j)) begin
        w_wlane = r_store_lane[j];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and memory-port outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (w_len_clamp != 4'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        mem_addr = r_addr;
        // Out-of-range elements still take their cycle but never strobe.
        mem_re   = !r_op && w_in_range;
        mem_we   =  r_op && w_in_range;
        if (r_op) begin
          mem_wdata = w_wlane;
        end
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Reset silences the port in the very cycle it is asserted, so an access
    // that is in flight when reset arrives is never committed by the memory.
    if (!rst) begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Command latch, address walk and lane capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op     <= 1'b0;
      r_addr   <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      for (int j = 0; j < VLEN; j++) begin
        r_store_lane[j] <= '0;
        r_load_lane[j]  <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_addr   <= base;
            r_stride <= stride;
            r_len    <= w_len_clamp;
            r_idx    <= '0;
            r_err    <= 1'b0;
            for (int j = 0; j < VLEN; j++) begin
              r_store_lane[j] <= store_data[j*DW +: DW];
              // A new load starts from a clean buffer so lanes >= len read 0;
              // a store leaves the previous load result untouched.
              if (!op) begin
                r_load_lane[j] <= '0;
              end
            end
          end
        end
        ST_RUN: begin
          // Element addresses are accumulated, never multiplied.
          r_addr <= r_addr + r_stride;
          r_idx  <= r_idx + 4'd1;
          if (!w_in_range) begin
            r_err <= 1'b1;
          end
          if (!r_op) begin
            for (int j = 0; j < VLEN; j++) begin
              if (r_idx == 4'(j)) begin
                r_load_lane[j] <= w_in_range ? mem_rdata : '0;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign err = r_err;

  for (genvar g = 0; g < VLEN; g++) begin : g_lane_pack
    assign load_data[g*DW +: DW] = r_load_lane[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vec_lsu
//  Purpose  : Self-checking bench for vec_lsu with a behavioural data memory.
//             Stimulus pushes expected accesses and completions into a queue;
//             a monitor pops and compares whenever the DUT strobes the memory
//             or pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vec_lsu;

  localparam int VLEN  = 8;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 128;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               op = 1'b0;
  logic [AW-1:0]      base = '0;
  logic [AW-1:0]      stride = '0;
  logic [3:0]         len = '0;
  logic [VLEN*DW-1:0] store_data = '0;
  logic [VLEN*DW-1:0] load_data;
  logic               busy;
  logic               done;
  logic               err;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic [DW-1:0]      mem_rdata;

  always #5 clk = ~clk;

  vec_lsu #(.VLEN(VLEN), .DW(DW), .AW(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .base       (base),
    .stride     (stride),
    .len        (len),
    .store_data (store_data),
    .load_data  (load_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Data memory: reinitialised to a known pattern while reset is held
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  int wr_cnt = 0;
  int rd_cnt = 0;

  function automatic logic [DW-1:0] mem_init(input int k);
    if (k >= 8 && k <= 11) return 32'hA0 + 32'(k - 8);
    return 32'h1000 + 32'(k);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= mem_init(k);
    end else if (mem_we && mem_addr < 32'(DEPTH)) begin
      mem[mem_addr[6:0]] <= mem_wdata;
    end
    if (mem_we) wr_cnt <= wr_cnt + 1;
    if (mem_re) rd_cnt <= rd_cnt + 1;
  end

  assign mem_rdata = (mem_re && mem_addr < 32'(DEPTH)) ? mem[mem_addr[6:0]] : 32'hDEAD_BEEF;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    bit                 is_done;
    bit                 we;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [VLEN*DW-1:0] ld;
    bit                 err;
    int                 busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]      ref_mem [DEPTH];
  logic [VLEN*DW-1:0] model_ld = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  int busy_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (mem_re || mem_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_access: got addr=%0h we=%0b re=%0b, expected no access",
                   mem_addr, mem_we, mem_re);
        end else begin
          e = exp_q.pop_front();
          check("access_slot", 256'(e.is_done), 256'(0));
          check("access_strobes", 256'({mem_we, mem_re}), 256'({e.we, ~e.we}));
          check("access_addr", 256'(mem_addr), 256'(e.addr));
          if (e.we) check("access_wdata", 256'(mem_wdata), 256'(e.wdata));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("done_slot", 256'(e.is_done), 256'(1));
          check("done_load_data", load_data, e.ld);
          check("done_err", 256'(err), 256'(e.err));
          check("done_busy_cycles", 256'(busy_run), 256'(e.busy_cycles));
        end
        busy_run = 0;
      end
      if (!busy) begin
        check("idle_port_quiet", 256'({mem_we, mem_re, mem_addr, mem_wdata}), 256'(0));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = mem_init(k);
    model_ld = '0;
  endtask

  // Pushes the expected accesses and completion, issues the command and
  // checks the done latency. Returns one cycle after done, back in IDLE.
  task automatic run_cmd(input bit o, input logic [31:0] b, input logic [31:0] s,
                         input logic [3:0] l, input logic [255:0] sd, input bit pulse_mid);
    int n;
    int got;
    logic [31:0] a;
    logic [255:0] ld;
    bit e_err;
    exp_t e;
    n     = (l > 4'd8) ? 8 : int'(l);
    ld    = o ? model_ld : '0;
    e_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(i) * s;
      if (a < 32'(DEPTH)) begin
        e = '{is_done: 1'b0, we: o, addr: a, wdata: (o ? sd[i*32 +: 32] : 32'h0),
              ld: '0, err: 1'b0, busy_cycles: 0};
        exp_q.push_back(e);
        if (o) ref_mem[a[6:0]] = sd[i*32 +: 32];
        else   ld[i*32 +: 32]  = ref_mem[a[6:0]];
      end else begin
        e_err = 1'b1;
      end
    end
    e = '{is_done: 1'b1, we: 1'b0, addr: '0, wdata: '0, ld: ld, err: e_err, busy_cycles: n};
    exp_q.push_back(e);
    model_ld = ld;

    op = o; base = b; stride = s; len = l; store_data = sd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int c = 1; c <= 40 && got == 0; c++) begin
      @(negedge clk);
      if (pulse_mid && c == 2) start = 1'b1;
      if (pulse_mid && c == 3) start = 1'b0;
      if (done) got = c;
    end
    check("done_latency", 256'(got), 256'(n + 1));
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int r0;
    int w0;
    logic [255:0] sd;

    // Reset held for two cycles
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_done", 256'(done), 256'(0));
    check("reset_err", 256'(err), 256'(0));
    check("reset_port", 256'({mem_we, mem_re, mem_addr, mem_wdata}), 256'(0));
    check("reset_load_data", load_data, 256'(0));
    @(posedge clk);
    #1;

    // Unit-stride load of 8..11
    r0 = rd_cnt;
    run_cmd(1'b0, 32'd8, 32'd1, 4'd4, '0, 1'b0);
    check("unit_load_lanes", load_data, pack8(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0));
    check("unit_load_err", 256'(err), 256'(0));
    check("unit_load_reads", 256'(rd_cnt - r0), 256'(4));

    // Strided store: base 2, stride 3, lanes 0x100+i
    for (int i = 0; i < 8; i++) sd[i*32 +: 32] = 32'h100 + 32'(i);
    w0 = wr_cnt;
    run_cmd(1'b1, 32'd2, 32'd3, 4'd8, sd, 1'b0);
    check("store_writes", 256'(wr_cnt - w0), 256'(8));
    check("store_mem2", 256'(mem[2]), 256'(32'h100));
    check("store_mem11", 256'(mem[11]), 256'(32'h103));
    check("store_mem23", 256'(mem[23]), 256'(32'h107));
    check("store_mem3_unchanged", 256'(mem[3]), 256'(32'h1003));
    check("store_mem24_unchanged", 256'(mem[24]), 256'(32'h1018));
    check("store_keeps_load_data", load_data, pack8(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0));

    // Load running off the top of memory
    r0 = rd_cnt;
    run_cmd(1'b0, 32'd126, 32'd1, 4'd4, '0, 1'b0);
    check("oor_lanes", load_data, pack8(32'h107E, 32'h107F, 0, 0, 0, 0, 0, 0));
    check("oor_reads", 256'(rd_cnt - r0), 256'(2));
    check("oor_err_sticky", 256'(err), 256'(1));

    // Negative stride; also clears err
    run_cmd(1'b0, 32'd3, 32'hFFFF_FFFF, 4'd4, '0, 1'b0);
    check("neg_stride_lanes", load_data, pack8(32'h1003, 32'h100, 32'h1001, 32'h1000, 0, 0, 0, 0));
    check("neg_stride_err_cleared", 256'(err), 256'(0));

    // len = 0
    r0 = rd_cnt;
    run_cmd(1'b0, 32'd5, 32'd1, 4'd0, '0, 1'b0);
    check("len0_reads", 256'(rd_cnt - r0), 256'(0));
    check("len0_load_data", load_data, 256'(0));

    // len = 15 clamps to 8
    r0 = rd_cnt;
    run_cmd(1'b0, 32'd20, 32'd1, 4'd15, '0, 1'b0);
    check("len15_reads", 256'(rd_cnt - r0), 256'(8));
    check("len15_lanes", load_data, pack8(32'h106, 32'h1015, 32'h1016, 32'h107,
                                          32'h1018, 32'h1019, 32'h101A, 32'h101B));

    // start pulsed again while running is ignored
    for (int i = 0; i < 8; i++) sd[i*32 +: 32] = 32'h300 + 32'(i);
    w0 = wr_cnt;
    run_cmd(1'b1, 32'd60, 32'd2, 4'd6, sd, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("restart_ignored_writes", 256'(wr_cnt - w0), 256'(6));
    check("restart_mem70", 256'(mem[70]), 256'(32'h305));

    // Reset on the third element of an 8-element store
    for (int i = 0; i < 8; i++) sd[i*32 +: 32] = 32'h200 + 32'(i);
    exp_q.push_back('{is_done: 1'b0, we: 1'b1, addr: 32'd40, wdata: 32'h200, ld: '0, err: 1'b0, busy_cycles: 0});
    exp_q.push_back('{is_done: 1'b0, we: 1'b1, addr: 32'd41, wdata: 32'h201, ld: '0, err: 1'b0, busy_cycles: 0});
    w0 = wr_cnt;
    op = 1'b1; base = 32'd40; stride = 32'd1; len = 4'd8; store_data = sd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_port", 256'({busy, done, err, mem_we, mem_re, mem_addr, mem_wdata}), 256'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_writes", 256'(wr_cnt - w0), 256'(2));
    check("midrst_outputs", 256'({busy, done, err, mem_we, mem_re}), 256'(0));
    check("midrst_load_data", load_data, 256'(0));
    check("midrst_queue_drained", 256'(exp_q.size()), 256'(0));
    @(posedge clk);
    #1;

    // Normal command after reset
    run_cmd(1'b0, 32'd8, 32'd1, 4'd2, '0, 1'b0);
    check("post_reset_lanes", load_data, pack8(32'hA0, 32'hA1, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    check("final_queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of sequence, expected completion within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
